glb_cfg_axil_bridge: RTL and testbench
======================================

// Module: glb_cfg_axil_bridge
// PURPOSE
//  AXI4-Lite slave that converts host register accesses into single-cycle cfg write/read pulses.
//  Drives the west cfg port of GLB tile 0 and collects the read data returned along the tile chain.
//  Allows one outstanding transaction; a read timeout returns SLVERR instead of hanging the bus.
// PARAMETERS
//  AXI_ADDR_WIDTH  12   AXI/cfg address width (byte address; tile select + register fields in upper bits)
//  AXI_DATA_WIDTH  32   AXI/cfg data width
//  RD_TIMEOUT      255  cycles to wait for cfg_rd_data_valid after cfg_rd_en; >= 1
// PORTS
//  clk               in   1               clock
//  reset             in   1               asynchronous, active-high reset
//  s_awaddr          in   AXI_ADDR_WIDTH  write address
//  s_awvalid         in   1               write address valid
//  s_awready         out  1               write address ready
//  s_wdata           in   AXI_DATA_WIDTH  write data
//  s_wstrb           in   AXI_DATA_WIDTH/8  write strobes
//  s_wvalid          in   1               write data valid
//  s_wready          out  1               write data ready
//  s_bresp           out  2               write response; 2'b00 OKAY, 2'b10 SLVERR
//  s_bvalid          out  1               write response valid
//  s_bready          in   1               write response ready
//  s_araddr          in   AXI_ADDR_WIDTH  read address
//  s_arvalid         in   1               read address valid
//  s_arready         out  1               read address ready
//  s_rdata           out  AXI_DATA_WIDTH  read data
//  s_rresp           out  2               read response; OKAY/SLVERR
//  s_rvalid          out  1               read data valid
//  s_rready          in   1               read data ready
//  cfg_wr_en         out  1               cfg write pulse to tile 0
//  cfg_wr_clk_en     out  1               constant 1
//  cfg_wr_addr       out  AXI_ADDR_WIDTH  cfg write address
//  cfg_wr_data       out  AXI_DATA_WIDTH  cfg write data
//  cfg_rd_en         out  1               cfg read pulse to tile 0
//  cfg_rd_clk_en     out  1               constant 1
//  cfg_rd_addr       out  AXI_ADDR_WIDTH  cfg read address
//  cfg_rd_data       in   AXI_DATA_WIDTH  returned read data
//  cfg_rd_data_valid in   1               returned read data valid (1-cycle pulse)
// BEHAVIOUR
//  Reset: all outputs 0 except *_clk_en = 1; FSM = IDLE; AW/W capture flags cleared; timeout counter 0.
//  Reset mid-transaction abandons it; no response is issued.
//  FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
//  - IDLE: s_awready = ~aw_captured; s_wready = ~w_captured. AW and W are latched independently, in any order.
//    - s_arready = 1 only when neither AW nor W is captured and no AW/W handshake occurs this cycle.
//    - Write wins if AR and a write become available in the same cycle.
//  - Both AW and W captured -> WR_ISSUE.
//    - With s_wstrb all ones: cfg_wr_en = 1 for exactly 1 cycle, carrying the captured addr/data.
//    - With a partial s_wstrb: no cfg write, and bresp = SLVERR.
//    - Then WR_RESP.
//  - WR_RESP: s_bvalid held until s_bready; then IDLE and capture flags cleared.
//  - AR handshake -> RD_ISSUE: cfg_rd_en = 1 for 1 cycle with cfg_rd_addr = captured araddr, then RD_WAIT.
//  - RD_WAIT: counter increments each cycle.
//    - On cfg_rd_data_valid: capture cfg_rd_data, rresp = OKAY, go to RD_RESP.
//    - Else when counter == RD_TIMEOUT-1: rdata = 0, rresp = SLVERR, go to RD_RESP.
//    - Valid in the same cycle as the timeout takes the data (OKAY).
//  - RD_RESP: s_rvalid and rdata/rresp held stable until s_rready, then IDLE.
//  - cfg_wr_en and cfg_rd_en are never high in the same cycle.
//  - cfg_wr_addr/cfg_wr_data/cfg_rd_addr are 0 when their enable is low.
//  - cfg_rd_data_valid outside RD_WAIT is ignored. A late response that arrives during a later RD_WAIT is accepted.
//    This is a known limitation: RD_TIMEOUT must exceed the worst-case chain round trip.
//  Latency: AW+W handshake in cycle N -> cfg_wr_en N+1 -> s_bvalid N+2.
//    AR in N -> cfg_rd_en N+1; cfg_rd_data_valid in M -> s_rvalid M+1.
//  Addresses are passed unmodified, low byte-offset bits included.
// TESTING
//  - AW+W same cycle, addr 0x204, data 0xDEADBEEF, wstrb 4'hF -> cfg_wr_en 1 cycle at N+1 (0x204, 0xDEADBEEF); bvalid N+2, OKAY.
//  - W 3 cycles before AW, bready low 5 cycles -> exactly one cfg_wr_en; bvalid held 5 cycles.
//    No AR accepted while AW/W are captured.
//  - wstrb 4'h3 -> no cfg_wr_en; bresp 2'b10.
//  - AR 0x108; model returns valid + 0x12345678 after 7 cycles -> one cfg_rd_en (0x108); rvalid one cycle after valid, rdata 0x12345678, OKAY.
//  - RD_TIMEOUT=16, no return -> rvalid 17 cycles after cfg_rd_en, rdata 0, rresp 2'b10.
//  - AR and AW+W same cycle -> write serviced first, then read; reset asserted in RD_WAIT -> all outputs 0, next read completes normally.

Source files
------------

// File: rtl/glb_cfg_axil_bridge.sv
// AXI4-Lite slave bridging host register accesses onto the GLB cfg bus.
// Write: AW and W are captured independently; once both are held a single
// cfg_wr_en pulse is issued (full strobes only), followed by a B response.
// Read: an AR handshake issues a single cfg_rd_en pulse, then waits for the
// tile chain to return data. A bounded wait turns a lost response into
// SLVERR instead of stalling the host bus. One transaction in flight at a time.
module glb_cfg_axil_bridge #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int RD_TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [AXI_ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                          s_awvalid,
    output logic                          s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                          s_wvalid,
    output logic                          s_wready,
    output logic [1:0]                    s_bresp,
    output logic                          s_bvalid,
    input  logic                          s_bready,

    input  logic [AXI_ADDR_WIDTH-1:0]     s_araddr,
    input  logic                          s_arvalid,
    output logic                          s_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rvalid,
    input  logic                          s_rready,

    output logic                          cfg_wr_en,
    output logic                          cfg_wr_clk_en,
    output logic [AXI_ADDR_WIDTH-1:0]     cfg_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]     cfg_wr_data,
    output logic                          cfg_rd_en,
    output logic                          cfg_rd_clk_en,
    output logic [AXI_ADDR_WIDTH-1:0]     cfg_rd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cfg_rd_data,
    input  logic                          cfg_rd_data_valid
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    // Counter must be able to hold RD_TIMEOUT-1 even when RD_TIMEOUT == 1.
    localparam int CNT_WIDTH  = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RD_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;

    logic                      aw_captured_reg;
    logic                      w_captured_reg;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_reg;
    logic [AXI_DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0]     wstrb_reg;
    logic [AXI_ADDR_WIDTH-1:0] araddr_reg;
    logic [AXI_DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]                rresp_reg;
    logic [CNT_WIDTH-1:0]      cnt_reg;

    logic                      in_idle;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      ar_hs;
    logic                      b_hs;
    logic                      r_hs;
    logic                      write_ready;
    logic                      wstrb_full;
    logic                      rd_timeout_hit;

    // Handshakes only happen in IDLE; ready outputs are also held low while
    // reset is asserted so the whole host interface reads as quiet.
    assign in_idle        = (state_reg == IDLE) && !reset;
    assign s_awready      = in_idle && !aw_captured_reg;
    assign s_wready       = in_idle && !w_captured_reg;
    assign aw_hs          = s_awvalid && s_awready;
    assign w_hs           = s_wvalid && s_wready;
    // A write in progress (captured or completing a handshake now) blocks
    // reads, which gives writes priority on a same-cycle collision.
    assign s_arready      = in_idle && !aw_captured_reg && !w_captured_reg
                            && !aw_hs && !w_hs;
    assign ar_hs          = s_arvalid && s_arready;
    assign b_hs           = s_bvalid && s_bready;
    assign r_hs           = s_rvalid && s_rready;
    assign write_ready    = (aw_captured_reg || aw_hs) && (w_captured_reg || w_hs);
    assign wstrb_full     = &wstrb_reg;
    assign rd_timeout_hit = (cnt_reg == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (write_ready) begin
                    state_next = WR_ISSUE;
                end else if (ar_hs) begin
                    state_next = RD_ISSUE;
                end
            end
            WR_ISSUE: state_next = WR_RESP;
            WR_RESP: begin
                if (s_bready) begin
                    state_next = IDLE;
                end
            end
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT: begin
                if (cfg_rd_data_valid || rd_timeout_hit) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write address capture; the flag stays set until the B handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_captured_reg <= 1'b0;
            awaddr_reg      <= '0;
        end else if (b_hs) begin
            aw_captured_reg <= 1'b0;
        end else if (aw_hs) begin
            aw_captured_reg <= 1'b1;
            awaddr_reg      <= s_awaddr;
        end
    end

    // Write data/strobe capture; the flag stays set until the B handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_captured_reg <= 1'b0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
        end else if (b_hs) begin
            w_captured_reg <= 1'b0;
        end else if (w_hs) begin
            w_captured_reg <= 1'b1;
            wdata_reg      <= s_wdata;
            wstrb_reg      <= s_wstrb;
        end
    end

    // Read address capture on the AR handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            araddr_reg <= '0;
        end else if (ar_hs) begin
            araddr_reg <= s_araddr;
        end
    end

    // Response wait counter: cleared while issuing, counts every RD_WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (state_reg == RD_ISSUE) begin
            cnt_reg <= '0;
        end else if (state_reg == RD_WAIT) begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    // Read response capture; returned data wins over a coincident timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
            rresp_reg <= RESP_OKAY;
        end else if (state_reg == RD_WAIT) begin
            if (cfg_rd_data_valid) begin
                rdata_reg <= cfg_rd_data;
                rresp_reg <= RESP_OKAY;
            end else if (rd_timeout_hit) begin
                rdata_reg <= '0;
                rresp_reg <= RESP_SLVERR;
            end
        end
    end

    // cfg bus drive: address/data lines are zero whenever their enable is low.
    always_comb begin
        cfg_wr_en   = (state_reg == WR_ISSUE) && wstrb_full;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        cfg_rd_en   = (state_reg == RD_ISSUE);
        cfg_rd_addr = '0;
        if (cfg_wr_en) begin
            cfg_wr_addr = awaddr_reg;
            cfg_wr_data = wdata_reg;
        end
        if (cfg_rd_en) begin
            cfg_rd_addr = araddr_reg;
        end
    end

    assign cfg_wr_clk_en = 1'b1;
    assign cfg_rd_clk_en = 1'b1;

    // Host responses: a partial strobe was never written, so it reports SLVERR.
    always_comb begin
        s_bvalid = (state_reg == WR_RESP);
        s_bresp  = RESP_OKAY;
        s_rvalid = (state_reg == RD_RESP);
        s_rdata  = '0;
        s_rresp  = RESP_OKAY;
        if (s_bvalid && !wstrb_full) begin
            s_bresp = RESP_SLVERR;
        end
        if (s_rvalid) begin
            s_rdata = rdata_reg;
            s_rresp = rresp_reg;
        end
    end

endmodule

// File: tb/tb_glb_cfg_axil_bridge.sv
// Bench for glb_cfg_axil_bridge: directed latency/boundary cases followed by
// randomized write/read traffic, checked every cycle against a bus-level model.
module tb_glb_cfg_axil_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] s_awaddr = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [DW-1:0] s_wdata = '0;
    logic [SW-1:0] s_wstrb = '0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b0;
    logic [AW-1:0] s_araddr = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready = 1'b0;
    logic          cfg_wr_en;
    logic          cfg_wr_clk_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [DW-1:0] cfg_wr_data;
    logic          cfg_rd_en;
    logic          cfg_rd_clk_en;
    logic [AW-1:0] cfg_rd_addr;
    logic [DW-1:0] cfg_rd_data = '0;
    logic          cfg_rd_data_valid = 1'b0;

    glb_cfg_axil_bridge #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .RD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_clk_en(cfg_wr_clk_en),
        .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_rd_en(cfg_rd_en), .cfg_rd_clk_en(cfg_rd_clk_en), .cfg_rd_addr(cfg_rd_addr),
        .cfg_rd_data(cfg_rd_data), .cfg_rd_data_valid(cfg_rd_data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tmo(input string name);
        n_total++;
        $display("FAIL %s: bound expired without handshake (cycle %0d)", name, cyc);
    endtask

    // Tile-chain responder settings for the next read (latency in cycles after cfg_rd_en).
    int            rsp_lat  = 1;
    logic [DW-1:0] rsp_data = '0;

    // ---------------- bus-level model and per-cycle compare ----------------
    bit            m_aw_got, m_w_got, m_wr_act, m_rd_act, m_r_set;
    int            m_aw_c, m_w_c, m_wr_c, m_ar_c, m_r_c;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [1:0]    m_rresp;
    // observation records used by the directed checks
    int            wr_pulses = 0, rd_pulses = 0;
    int            last_wr_c, last_rd_c, aw_hs_c, w_hs_c, ar_hs_c, b_hs_c, r_hs_c;
    int            b_rise_c, r_rise_c, b_low = 0, b_hold = 0;
    logic [AW-1:0] last_wr_addr, last_rd_addr;
    logic [DW-1:0] last_wr_data, last_rdata;
    logic [1:0]    last_bresp, last_rresp;
    bit            prev_bvalid = 0, prev_rvalid = 0;

    always @(negedge clk) begin
        bit exp_awr, exp_wr, exp_arr, exp_wen, exp_ren, exp_bv, exp_rv, full;
        if (reset) begin
            m_aw_got = 0; m_w_got = 0; m_wr_act = 0; m_rd_act = 0; m_r_set = 0;
            prev_bvalid = 0; prev_rvalid = 0; b_low = 0;
        end else begin
            full    = (m_wstrb == '1);
            exp_awr = !m_aw_got && !m_wr_act && !m_rd_act;
            exp_wr  = !m_w_got && !m_wr_act && !m_rd_act;
            exp_arr = !m_aw_got && !m_w_got && !m_rd_act && !m_wr_act
                      && !(s_awvalid && exp_awr) && !(s_wvalid && exp_wr);
            exp_wen = m_wr_act && (cyc == m_wr_c) && full;
            exp_ren = m_rd_act && (cyc == m_ar_c + 1);
            exp_bv  = m_wr_act && (cyc > m_wr_c);
            exp_rv  = m_r_set && (cyc >= m_r_c);

            chk("awready", s_awready, exp_awr);
            chk("wready", s_wready, exp_wr);
            chk("arready", s_arready, exp_arr);
            chk("cfg_wr_en", cfg_wr_en, exp_wen);
            chk("cfg_wr_addr", cfg_wr_addr, exp_wen ? m_awaddr : '0);
            chk("cfg_wr_data", cfg_wr_data, exp_wen ? m_wdata : '0);
            chk("cfg_rd_en", cfg_rd_en, exp_ren);
            chk("cfg_rd_addr", cfg_rd_addr, exp_ren ? m_araddr : '0);
            chk("wr_rd_exclusive", cfg_wr_en & cfg_rd_en, 0);
            chk("clk_en", {cfg_wr_clk_en, cfg_rd_clk_en}, 2'b11);
            chk("bvalid", s_bvalid, exp_bv);
            if (exp_bv) chk("bresp", s_bresp, full ? 2'b00 : 2'b10);
            chk("rvalid", s_rvalid, exp_rv);
            if (exp_rv) begin
                chk("rdata", s_rdata, m_rdata);
                chk("rresp", s_rresp, m_rresp);
            end

            if (cfg_wr_en) begin
                wr_pulses++; last_wr_c = cyc; last_wr_addr = cfg_wr_addr; last_wr_data = cfg_wr_data;
            end
            if (cfg_rd_en) begin
                rd_pulses++; last_rd_c = cyc; last_rd_addr = cfg_rd_addr;
            end
            if (exp_ren) begin
                // Data returned within RD_TIMEOUT cycles is taken; otherwise SLVERR after the bound.
                m_r_set = 1;
                m_r_c   = cyc + ((rsp_lat <= TO) ? rsp_lat : TO) + 1;
                m_rdata = (rsp_lat <= TO) ? rsp_data : '0;
                m_rresp = (rsp_lat <= TO) ? 2'b00 : 2'b10;
            end
            if (s_bvalid && !prev_bvalid) b_rise_c = cyc;
            if (s_rvalid && !prev_rvalid) r_rise_c = cyc;
            if (s_bvalid && !s_bready) b_low++;
            if (s_bvalid && s_bready) begin
                b_hs_c = cyc; b_hold = b_low; b_low = 0; last_bresp = s_bresp;
                $display("wr addr=0x%03h data=0x%08h strb=0x%0h bresp=%0d", m_awaddr, m_wdata, m_wstrb, s_bresp);
                m_aw_got = 0; m_w_got = 0; m_wr_act = 0;
            end
            if (s_rvalid && s_rready) begin
                r_hs_c = cyc; last_rdata = s_rdata; last_rresp = s_rresp;
                $display("rd addr=0x%03h rdata=0x%08h rresp=%0d", m_araddr, s_rdata, s_rresp);
                m_rd_act = 0; m_r_set = 0;
            end
            if (s_awvalid && s_awready) begin
                m_aw_got = 1; m_aw_c = cyc; m_awaddr = s_awaddr; aw_hs_c = cyc;
            end
            if (s_wvalid && s_wready) begin
                m_w_got = 1; m_w_c = cyc; m_wdata = s_wdata; m_wstrb = s_wstrb; w_hs_c = cyc;
            end
            if (m_aw_got && m_w_got && !m_wr_act) begin
                m_wr_act = 1;
                m_wr_c   = ((m_aw_c > m_w_c) ? m_aw_c : m_w_c) + 1;
            end
            if (s_arvalid && s_arready) begin
                m_rd_act = 1; m_ar_c = cyc; m_araddr = s_araddr; ar_hs_c = cyc;
            end
            prev_bvalid = s_bvalid;
            prev_rvalid = s_rvalid;
        end
    end

    // Tile-chain responder: one valid pulse rsp_lat cycles after cfg_rd_en,
    // or silence when the latency exceeds the timeout.
    initial forever begin
        @(negedge clk);
        if (!reset && cfg_rd_en && rsp_lat <= TO) begin
            int            lat;
            logic [DW-1:0] d;
            lat = rsp_lat;
            d   = rsp_data;
            repeat (lat) @(posedge clk);
            #1 cfg_rd_data = d; cfg_rd_data_valid = 1'b1;
            @(posedge clk);
            #1 cfg_rd_data = '0; cfg_rd_data_valid = 1'b0;
        end
    end

    // ---------------- drivers (entered and left at posedge+1) ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] st,
                            input int aw_dly, input int w_dly, input int b_low_cycles);
        bit ok_aw, ok_w, ok_b;
        fork
            begin
                repeat (aw_dly) @(posedge clk);
                #1 s_awaddr = a; s_awvalid = 1'b1;
                ok_aw = 0;
                for (int k = 0; k < 300 && !ok_aw; k++) begin @(negedge clk); ok_aw = s_awready; end
                if (!ok_aw) tmo("aw_handshake");
                @(posedge clk); #1 s_awvalid = 1'b0; s_awaddr = '0;
            end
            begin
                repeat (w_dly) @(posedge clk);
                #1 s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
                ok_w = 0;
                for (int k = 0; k < 300 && !ok_w; k++) begin @(negedge clk); ok_w = s_wready; end
                if (!ok_w) tmo("w_handshake");
                @(posedge clk); #1 s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
            end
        join
        ok_b = 0;
        for (int k = 0; k < 300 && !ok_b; k++) begin @(negedge clk); ok_b = s_bvalid; end
        if (!ok_b) tmo("bvalid");
        repeat (b_low_cycles) @(posedge clk);
        #1 s_bready = 1'b1;
        @(posedge clk); #1 s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int lat, input logic [DW-1:0] d,
                           input int ar_dly, input int r_low_cycles);
        bit ok_ar, ok_r;
        rsp_lat  = lat;
        rsp_data = d;
        repeat (ar_dly) @(posedge clk);
        #1 s_araddr = a; s_arvalid = 1'b1;
        ok_ar = 0;
        for (int k = 0; k < 300 && !ok_ar; k++) begin @(negedge clk); ok_ar = s_arready; end
        if (!ok_ar) tmo("ar_handshake");
        @(posedge clk); #1 s_arvalid = 1'b0; s_araddr = '0;
        ok_r = 0;
        for (int k = 0; k < 300 && !ok_r; k++) begin @(negedge clk); ok_r = s_rvalid; end
        if (!ok_r) tmo("rvalid");
        repeat (r_low_cycles) @(posedge clk);
        #1 s_rready = 1'b1;
        @(posedge clk); #1 s_rready = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ctl"}, {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                            cfg_wr_en, cfg_rd_en, s_bresp, s_rresp}, 0);
        chk({tag, "_rdata"}, s_rdata, 0);
        chk({tag, "_cfg_addr"}, {cfg_wr_addr, cfg_rd_addr}, 0);
        chk({tag, "_cfg_wdata"}, cfg_wr_data, 0);
        chk({tag, "_clk_en"}, {cfg_wr_clk_en, cfg_rd_clk_en}, 2'b11);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p0, r0, hs;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // AW+W together: pulse at N+1, bvalid at N+2, OKAY
        p0 = wr_pulses;
        do_write(12'h204, 32'hDEADBEEF, 4'hF, 0, 0, 1);
        chk("t1_aw_w_same_cycle", aw_hs_c, w_hs_c);
        chk("t1_wr_pulses", wr_pulses - p0, 1);
        chk("t1_wr_latency", last_wr_c - aw_hs_c, 1);
        chk("t1_wr_addr", last_wr_addr, 12'h204);
        chk("t1_wr_data", last_wr_data, 32'hDEADBEEF);
        chk("t1_b_latency", b_rise_c - aw_hs_c, 2);
        chk("t1_bresp", last_bresp, 2'b00);

        // W three cycles before AW, bready low 5 cycles, AR pending meanwhile
        p0 = wr_pulses;
        fork
            do_write(12'h310, 32'hA5A50F0F, 4'hF, 3, 0, 5);
            do_read(12'h0AC, 4, 32'h0F1E2D3C, 1, 1);
        join
        chk("t2_w_before_aw", aw_hs_c - w_hs_c, 3);
        chk("t2_wr_pulses", wr_pulses - p0, 1);
        chk("t2_bvalid_held", b_hold, 5);
        chk("t2_ar_after_b", ar_hs_c > b_hs_c, 1);
        chk("t2_rdata", last_rdata, 32'h0F1E2D3C);

        // partial strobe: no cfg write, SLVERR
        p0 = wr_pulses;
        do_write(12'h0F0, 32'h11223344, 4'h3, 0, 0, 1);
        chk("t3_no_wr_pulse", wr_pulses - p0, 0);
        chk("t3_bresp", last_bresp, 2'b10);

        // read with 7-cycle return
        r0 = rd_pulses;
        do_read(12'h108, 7, 32'h12345678, 0, 1);
        chk("t4_rd_pulses", rd_pulses - r0, 1);
        chk("t4_rd_addr", last_rd_addr, 12'h108);
        chk("t4_rd_latency", last_rd_c - ar_hs_c, 1);
        chk("t4_rvalid_latency", r_rise_c - last_rd_c, 8);
        chk("t4_rdata", last_rdata, 32'h12345678);
        chk("t4_rresp", last_rresp, 2'b00);

        // no return: SLVERR 17 cycles after cfg_rd_en
        do_read(12'h3FC, 100, 32'h99999999, 0, 2);
        chk("t5_timeout_latency", r_rise_c - last_rd_c, 17);
        chk("t5_timeout_rdata", last_rdata, 32'h0);
        chk("t5_timeout_rresp", last_rresp, 2'b10);

        // return in the very cycle of the timeout: data wins
        do_read(12'h3F8, 16, 32'hFEEDC0DE, 0, 1);
        chk("t5b_edge_latency", r_rise_c - last_rd_c, 17);
        chk("t5b_edge_rdata", last_rdata, 32'hFEEDC0DE);
        chk("t5b_edge_rresp", last_rresp, 2'b00);

        // AR and AW+W in the same cycle: write first
        p0 = wr_pulses;
        fork
            do_write(12'h040, 32'hCAFEF00D, 4'hF, 0, 0, 2);
            do_read(12'h044, 3, 32'h0BADF00D, 0, 1);
        join
        chk("t6_write_first", ar_hs_c > b_hs_c, 1);
        chk("t6_wr_pulses", wr_pulses - p0, 1);
        chk("t6_rdata", last_rdata, 32'h0BADF00D);

        // reset while waiting for read data, then a normal read
        rsp_lat = 100;
        #1 s_araddr = 12'h2A0; s_arvalid = 1'b1;
        hs = 0;
        for (int k = 0; k < 50 && hs == 0; k++) begin @(negedge clk); hs = s_arready ? 1 : 0; end
        if (hs == 0) tmo("t7_ar_handshake");
        @(posedge clk); #1 s_arvalid = 1'b0; s_araddr = '0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        reset_checks("t7_midreset");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        do_read(12'h200, 5, 32'h5555AAAA, 0, 1);
        chk("t7_after_reset_rdata", last_rdata, 32'h5555AAAA);
        chk("t7_after_reset_rresp", last_rresp, 2'b00);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            int            kind, lat;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [SW-1:0] st;
            kind = $urandom_range(0, 3);
            a    = AW'($urandom);
            d    = $urandom;
            st   = ($urandom_range(0, 3) != 0) ? 4'hF : SW'($urandom_range(0, 14));
            lat  = $urandom_range(1, TO + 4);
            case (kind)
                0, 1: do_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 3));
                2:    do_read(a, lat, d, $urandom_range(0, 2), $urandom_range(1, 3));
                default: fork
                    do_write(a, d, st, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 3));
                    do_read(a ^ 12'h004, lat, ~d, $urandom_range(0, 2), $urandom_range(1, 3));
                join
            endcase
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
